stack_arbiter: RTL

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/stack_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared types for the stack arbiter: stack command encoding, controller states, op codes.
package stack_pkg;

    typedef enum logic [1:0] {
        NOP  = 2'b00,
        PUSH = 2'b01,
        POP  = 2'b10
    } t_stack_cmd;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } t_ctrl_state;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    // Index width for a requester count, never narrower than one bit.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: lowest requesting index at or above ptr, else wrap to the lowest overall.
module rr_arbiter
    import stack_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates push/pop requests from several requesters onto one external stack,
// one command per grant, with occupancy tracking and early rejection of over/underflow.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned NUM_REQ   = 2
) (
    input  logic                          in_clk,
    input  logic                          in_rst,
    input  logic [NUM_REQ-1:0]            in_req,
    input  logic [NUM_REQ-1:0]            in_op,
    input  logic [NUM_REQ*WORD_BITS-1:0]  in_wdata,
    output logic [NUM_REQ-1:0]            out_ack,
    output logic                          out_err,
    output logic [WORD_BITS-1:0]          out_rdata,
    output logic [ADDR_BITS:0]            out_count,
    output logic                          out_full,
    output logic                          out_empty,
    output logic                          out_busy,
    output logic [1:0]                    out_stack_cmd,
    output logic [WORD_BITS-1:0]          out_stack_data,
    input  logic [WORD_BITS-1:0]          in_stack_top,
    input  logic                          in_stack_ready
);

    localparam int unsigned IDX_W = idx_bits(NUM_REQ);
    localparam int unsigned CNT_W = ADDR_BITS + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    t_ctrl_state            state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]     gnt_oh;
    logic                   op_q;
    logic [WORD_BITS-1:0]   rd_cap;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   op_sel;
    logic [WORD_BITS-1:0]   wdata_sel;
    logic                   reject;
    logic [IDX_W-1:0]       ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (in_req),
        .ptr   (ptr),
        .grant (arb_gnt),
        .idx   (arb_idx)
    );

    assign out_full  = (out_count == CNT_W'(DEPTH));
    assign out_empty = (out_count == '0);

    // Op and data of the requester the arbiter currently selects.
    always_comb begin
        op_sel    = OP_PUSH;
        wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                op_sel    = in_op[i];
                wdata_sel = in_wdata[i*WORD_BITS +: WORD_BITS];
            end
        end
    end

    assign reject   = ((op_sel == OP_PUSH) && out_full) || ((op_sel == OP_POP) && out_empty);
    assign ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state          <= ST_IDLE;
            ptr            <= '0;
            gnt_idx        <= '0;
            gnt_oh         <= '0;
            op_q           <= OP_PUSH;
            rd_cap         <= '0;
            out_ack        <= '0;
            out_err        <= 1'b0;
            out_rdata      <= '0;
            out_count      <= '0;
            out_busy       <= 1'b0;
            out_stack_cmd  <= NOP;
            out_stack_data <= '0;
        end else begin
            out_ack       <= '0;
            out_err       <= 1'b0;
            out_stack_cmd <= NOP;
            case (state)
                ST_IDLE: begin
                    if (in_stack_ready && (|in_req)) begin
                        gnt_idx  <= arb_idx;
                        gnt_oh   <= arb_gnt;
                        op_q     <= op_sel;
                        out_busy <= 1'b1;
                        if (reject) begin
                            out_ack <= arb_gnt;
                            out_err <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            out_stack_cmd  <= (op_sel == OP_POP) ? POP : PUSH;
                            out_stack_data <= wdata_sel;
                            state          <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Top of stack is still the word being popped during the issue cycle.
                    if (op_q == OP_POP) begin
                        rd_cap <= in_stack_top;
                    end
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (in_stack_ready) begin
                        if (op_q == OP_PUSH) begin
                            if (out_count != CNT_W'(DEPTH)) begin
                                out_count <= out_count + CNT_W'(1);
                            end
                        end else begin
                            if (out_count != '0) begin
                                out_count <= out_count - CNT_W'(1);
                            end
                            out_rdata <= rd_cap;
                        end
                        out_ack <= gnt_oh;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr      <= ptr_next;
                    out_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
